// File: rtl/mips_isa_pkg.sv
// MIPS32 encoding constants and decode-class bit positions shared by the decoder, the
// decode queue and EX.
package mips_isa_pkg;

  // Major opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  // COP0 rs selectors and the one exact-match encoding
  localparam logic [4:0]  RS_MF     = 5'h00;
  localparam logic [4:0]  RS_MT     = 5'h04;
  localparam logic [31:0] INST_ERET = 32'h4200_0018;

  // Bit positions in the one-hot class vector
  localparam int unsigned CLS_I_OPRT = 7;
  localparam int unsigned CLS_R_OPRT = 6;
  localparam int unsigned CLS_LOAD   = 5;
  localparam int unsigned CLS_STORE  = 4;
  localparam int unsigned CLS_MULDIV = 3;
  localparam int unsigned CLS_MOVE   = 2;
  localparam int unsigned CLS_JMP    = 1;
  localparam int unsigned CLS_EXC    = 0;

  typedef logic [7:0] cls_t;

endpackage

// File: rtl/inst_classify.sv
// Combinational MIPS32 instruction classifier: one-hot class vector plus reserved flag.
module inst_classify
  import mips_isa_pkg::*;
(
  input  logic [31:0] inst,
  output cls_t        cls,
  output logic        rsv
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, sa;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign sa    = inst[10:6];
  assign funct = inst[5:0];

  // Exact field checks; anything not matched leaves cls at zero.
  always_comb begin
    cls = '0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA:
            cls[CLS_R_OPRT] = (rs == 5'd0);
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
            cls[CLS_R_OPRT] = (sa == 5'd0);
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
            cls[CLS_MULDIV] = (rd == 5'd0) && (sa == 5'd0);
          FN_MFHI, FN_MFLO:
            cls[CLS_MOVE] = (rs == 5'd0) && (rt == 5'd0) && (sa == 5'd0);
          FN_MTHI, FN_MTLO:
            cls[CLS_MOVE] = (rt == 5'd0) && (rd == 5'd0) && (sa == 5'd0);
          FN_JR:
            cls[CLS_JMP] = (rt == 5'd0) && (rd == 5'd0);
          FN_JALR:
            cls[CLS_JMP] = (rt == 5'd0);
          FN_SYSCALL, FN_BREAK:
            cls[CLS_EXC] = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM:
        cls[CLS_JMP] = rt inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL};
      OP_J, OP_JAL, OP_BEQ, OP_BNE:
        cls[CLS_JMP] = 1'b1;
      OP_BLEZ, OP_BGTZ:
        cls[CLS_JMP] = (rt == 5'd0);
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
        cls[CLS_I_OPRT] = 1'b1;
      OP_LUI:
        cls[CLS_I_OPRT] = (rs == 5'd0);
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
        cls[CLS_LOAD] = 1'b1;
      OP_SB, OP_SH, OP_SW:
        cls[CLS_STORE] = 1'b1;
      OP_COP0: begin
        if ((rs == RS_MF || rs == RS_MT) && sa == 5'd0 && funct[4:3] == 2'b00) begin
          cls[CLS_MOVE] = 1'b1;
        end else if (inst == INST_ERET) begin
          cls[CLS_EXC] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rsv = ~|cls;

endmodule

// File: rtl/decode_queue.sv
// Decode front end: DEPTH-entry FIFO with empty-queue bypass, classifier on the selected
// source, registered valid/ready output stage, delay-slot tagging and flush.
module decode_queue
  import mips_isa_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [PC_W-1:0]  out_pc,
  output logic [7:0]       out_cls,
  output logic             out_rsv,
  output logic             out_in_ds,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_inst [DEPTH];
  logic [PC_W-1:0]  mem_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ds_q;

  logic             push, can_load, have_head, load_head, bypass, load, write;
  logic [31:0]      src_inst;
  logic [PC_W-1:0]  src_pc;
  cls_t             src_cls;
  logic             src_rsv;

  // Handshake and source selection; the bypass path only exists when the FIFO is empty.
  always_comb begin
    in_ready  = (count_q < CNT_W'(DEPTH));
    push      = in_valid & in_ready;
    can_load  = ~out_valid | out_ready;
    have_head = (count_q != '0);
    load_head = can_load & have_head;
    bypass    = can_load & ~have_head & push;
    load      = load_head | bypass;
    write     = push & ~bypass;
    src_inst  = have_head ? mem_inst[rd_ptr_q] : in_inst;
    src_pc    = have_head ? mem_pc[rd_ptr_q]   : in_pc;
    count_d   = count_q + CNT_W'(write) - CNT_W'(load_head);
  end

  inst_classify u_classify (
    .inst (src_inst),
    .cls  (src_cls),
    .rsv  (src_rsv)
  );

  // FIFO storage; entries are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (write) begin
      mem_inst[wr_ptr_q] <= in_inst;
      mem_pc[wr_ptr_q]   <= in_pc;
    end
  end

  // Pointers, occupancy, output register and delay-slot flag; flush beats everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ds_q      <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      out_cls   <= '0;
      out_rsv   <= 1'b0;
      out_in_ds <= 1'b0;
    end else if (flush) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ds_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      count_q <= count_d;
      if (write)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (load_head) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (load) begin
        out_valid <= 1'b1;
        out_inst  <= src_inst;
        out_pc    <= src_pc;
        out_cls   <= src_cls;
        out_rsv   <= src_rsv;
        out_in_ds <= ds_q;
        ds_q      <= src_cls[CLS_JMP];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed scenarios then random traffic, checked
// against an in-order stream model of accepted instructions.
module tb_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic [PC_W-1:0]  out_pc;
  logic [7:0]       out_cls;
  logic             out_rsv;
  logic             out_in_ds;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_cls   (out_cls),
    .out_rsv   (out_rsv),
    .out_in_ds (out_in_ds),
    .count     (count)
  );

  // Model: every accepted, unflushed instruction appears at the output in order; its
  // delay-slot tag is the jump class of the instruction accepted just before it.
  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic [7:0]      cls;
    logic            ds;
  } beat_t;

  beat_t mq[$];
  logic  last_jmp = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] m_count();
    return (mq.size() > 0) ? CNT_W'(mq.size() - 1) : '0;
  endfunction

  task automatic check_state();
    check("count", count, m_count());
    check("in_ready", in_ready, m_count() < DEPTH);
    check("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("out_inst", out_inst, mq[0].inst);
      check("out_pc", out_pc, mq[0].pc);
      check("out_cls", out_cls, mq[0].cls);
      check("out_rsv", out_rsv, mq[0].cls == 8'h00);
      check("out_in_ds", out_in_ds, mq[0].ds);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare 1 time unit later.
  task automatic step(input logic v, input logic [31:0] inst, input logic [PC_W-1:0] pc,
                      input logic [7:0] cls, input logic ordy, input logic fl);
    logic  push, fire;
    beat_t b;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    push = v && (m_count() < DEPTH);
    fire = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (fire) void'(mq.pop_front());
    if (fl) begin
      mq.delete();
      last_jmp = 1'b0;
    end else if (push) begin
      b.inst = inst;
      b.pc   = pc;
      b.cls  = cls;
      b.ds   = last_jmp;
      mq.push_back(b);
      last_jmp = cls[1];
    end
    #1;
    check_state();
  endtask

  // Random instruction built from a known class; corrupted variants must be reserved.
  function automatic void gen(output logic [31:0] inst, output logic [7:0] cls);
    logic [5:0]  alu_fn [13];
    logic [5:0]  sh_fn  [3];
    logic [5:0]  ld_op  [5];
    logic [5:0]  st_op  [3];
    logic [5:0]  br_op  [4];
    logic [4:0]  rim_rt [4];
    logic [5:0]  bad_op [5];
    logic [4:0]  rs, rt, rd, sa, nz, csel;
    logic [15:0] imm;
    alu_fn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
               6'h04, 6'h06, 6'h07};
    sh_fn  = '{6'h00, 6'h02, 6'h03};
    ld_op  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    st_op  = '{6'h28, 6'h29, 6'h2B};
    br_op  = '{6'h02, 6'h03, 6'h04, 6'h05};
    rim_rt = '{5'h00, 5'h01, 5'h10, 5'h11};
    bad_op = '{6'h34, 6'h37, 6'h3B, 6'h3C, 6'h3F};
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom);
    nz = 5'($urandom_range(1, 31));
    csel = ($urandom_range(0, 1) != 0) ? 5'h04 : 5'h00;
    imm = 16'($urandom);
    case ($urandom_range(0, 19))
      0:  begin inst = {6'h00, rs, rt, rd, 5'd0, alu_fn[$urandom_range(0, 12)]}; cls = 8'h40; end
      1:  begin inst = {6'h00, rs, rt, rd, nz, alu_fn[$urandom_range(0, 12)]};   cls = 8'h00; end
      2:  begin inst = {6'h00, 5'd0, rt, rd, sa, sh_fn[$urandom_range(0, 2)]};   cls = 8'h40; end
      3:  begin inst = {6'h00, nz, rt, rd, sa, sh_fn[$urandom_range(0, 2)]};     cls = 8'h00; end
      4:  begin inst = {6'($urandom_range(8, 14)), rs, rt, imm};                 cls = 8'h80; end
      5:  begin inst = {6'h0F, 5'd0, rt, imm};                                   cls = 8'h80; end
      6:  begin inst = {6'h0F, nz, rt, imm};                                     cls = 8'h00; end
      7:  begin inst = {ld_op[$urandom_range(0, 4)], rs, rt, imm};              cls = 8'h20; end
      8:  begin inst = {st_op[$urandom_range(0, 2)], rs, rt, imm};              cls = 8'h10; end
      9:  begin inst = {6'h00, rs, rt, 10'd0, 6'($urandom_range(24, 27))};      cls = 8'h08; end
      10: begin inst = {6'h00, rs, rt, nz, 5'd0, 6'($urandom_range(24, 27))};   cls = 8'h00; end
      11: begin
        if ($urandom_range(0, 1) != 0) inst = {6'h00, 10'd0, rd, 5'd0, 6'h10 | 6'(2 * $urandom_range(0, 1))};
        else                           inst = {6'h00, rs, 15'd0, 6'h11 | 6'(2 * $urandom_range(0, 1))};
        cls = 8'h04;
      end
      12: begin inst = {6'h10, csel, rt, rd, 5'd0, 6'($urandom_range(0, 7))};    cls = 8'h04; end
      13: begin inst = {6'h10, csel, rt, rd, nz, 6'($urandom_range(0, 7))};      cls = 8'h00; end
      14: begin inst = {br_op[$urandom_range(0, 3)], 26'($urandom)};            cls = 8'h02; end
      15: begin inst = {6'h01, rs, rim_rt[$urandom_range(0, 3)], imm};          cls = 8'h02; end
      16: begin inst = {6'h01, rs, 5'($urandom_range(2, 15)), imm};             cls = 8'h00; end
      17: begin
        case ($urandom_range(0, 2))
          0:       inst = {6'h00, rs, 15'd0, 6'h08};
          1:       inst = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
          default: inst = {6'($urandom_range(6, 7)), rs, 5'd0, imm};
        endcase
        cls = 8'h02;
      end
      18: begin
        if ($urandom_range(0, 3) == 0) inst = 32'h4200_0018;
        else inst = {6'h00, 20'($urandom), 6'($urandom_range(12, 13))};
        cls = 8'h01;
      end
      default: begin
        if ($urandom_range(0, 3) == 0) inst = 32'h4200_0019;
        else inst = {bad_op[$urandom_range(0, 4)], 26'($urandom)};
        cls = 8'h00;
      end
    endcase
  endfunction

  initial begin
    logic [31:0] r_inst;
    logic [7:0]  r_cls;

    // Reset state
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_cls", out_cls, 0);
    check("rst_out_rsv", out_rsv, 0);
    check("rst_out_in_ds", out_in_ds, 0);
    check("rst_in_ready", in_ready, 1);
    resetn = 1'b1;

    // Bypass latency: one cycle from push to out_valid on an empty queue
    step(1, 32'h0085_1021, 32'hBFC0_0000, 8'h40, 1, 0);
    check("lat_valid", out_valid, 1);
    check("lat_cls", out_cls, 8'h40);
    check("lat_rsv", out_rsv, 0);
    check("lat_ds", out_in_ds, 0);
    check("lat_count", count, 0);
    step(0, '0, '0, 8'h00, 1, 0);

    // Fill while stalled, refused push when full, then drain in order
    for (int i = 0; i < 5; i++) begin
      step(1, {6'h00, 5'(i), 5'd1, 5'd2, 5'd0, 6'h21}, 32'h1000 + 32'(4 * i), 8'h40, 0, 0);
    end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    step(1, 32'h0000_0000, 32'h2000, 8'h40, 0, 0);
    check("full_hold_count", count, 4);
    step(0, '0, '0, 8'h00, 1, 0);
    check("drain_count", count, 3);
    check("drain_in_ready", in_ready, 1);
    repeat (4) step(0, '0, '0, 8'h00, 1, 0);

    // Delay-slot tagging: beq, lw, sw
    step(0, '0, '0, 8'h00, 1, 1);
    step(1, 32'h1022_0003, 32'h3000, 8'h02, 1, 0);
    check("beq_cls", out_cls, 8'h02);
    check("beq_ds", out_in_ds, 0);
    step(1, 32'h8C43_0000, 32'h3004, 8'h20, 1, 0);
    check("lw_cls", out_cls, 8'h20);
    check("lw_ds", out_in_ds, 1);
    step(1, 32'hAC43_0004, 32'h3008, 8'h10, 1, 0);
    check("sw_cls", out_cls, 8'h10);
    check("sw_ds", out_in_ds, 0);

    // Reserved encodings
    step(1, 32'hFC00_0000, 32'h4000, 8'h00, 1, 0);
    check("rsv_op_rsv", out_rsv, 1);
    check("rsv_op_cls", out_cls, 8'h00);
    step(1, 32'h0022_1080, 32'h4004, 8'h00, 1, 0);
    check("rsv_sll_rsv", out_rsv, 1);
    check("rsv_sll_cls", out_cls, 8'h00);
    step(0, '0, '0, 8'h00, 1, 0);

    // Flush with a jal presented and three buffered; pushed beat is discarded
    step(1, 32'h0C00_0100, 32'h5000, 8'h02, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h2402_0001, 32'h5004 + 32'(4 * i), 8'h80, 0, 0);
    check("pre_flush_count", count, 3);
    step(1, 32'h2403_0002, 32'h5010, 8'h80, 0, 1);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    step(1, 32'h0085_1021, 32'h6000, 8'h40, 1, 0);
    check("post_flush_valid", out_valid, 1);
    check("post_flush_ds", out_in_ds, 0);
    step(0, '0, '0, 8'h00, 1, 0);

    // Asynchronous reset mid-cycle with two entries buffered
    step(1, 32'h1022_0003, 32'h7000, 8'h02, 0, 0);
    step(1, 32'h8C43_0000, 32'h7004, 8'h20, 0, 0);
    step(1, 32'hAC43_0004, 32'h7008, 8'h10, 0, 0);
    #3 resetn = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_inst", out_inst, 0);
    check("arst_pc", out_pc, 0);
    check("arst_cls", out_cls, 0);
    check("arst_ds", out_in_ds, 0);
    mq.delete();
    last_jmp = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    step(1, 32'h8C43_0000, 32'h8000, 8'h20, 1, 0);
    check("cold_ds", out_in_ds, 0);
    check("cold_cls", out_cls, 8'h20);
    step(0, '0, '0, 8'h00, 1, 0);

    // Random traffic with stalls and occasional flushes
    for (int n = 0; n < 600; n++) begin
      gen(r_inst, r_cls);
      step(($urandom_range(0, 3) != 0), r_inst, 32'($urandom) & 32'hFFFF_FFFC, r_cls,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, registered decode front end for the ID stage.
- Accepts fetched instruction/PC pairs through a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Classifies the head instruction: one-hot class vector plus a reserved-instruction flag. Tags branch delay slots.
- Presents the result to EX through a registered valid/ready output stage. Supports pipeline flush on branch redirect or exception.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2); the output register is not counted.
- PC_W, 32, PC width.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  discard all buffered and presented instructions.
- out_valid  out  1  output register holds a decoded instruction.
- out_ready  in  1  EX accepts the output.
- out_inst  out  32  instruction word.
- out_pc  out  PC_W  instruction PC.
- out_cls  out  8  one-hot class: [7] i_oprt, [6] r_oprt, [5] load, [4] store, [3] mul/div, [2] hi/lo/cp0 move, [1] jump/branch, [0] eret/syscall/break.
- out_rsv  out  1  no class matched (reserved instruction).
- out_in_ds  out  1  instruction occupies a branch delay slot.
- count  out  CNT_W  FIFO occupancy, excluding the output register.

Behaviour:
- Reset (async, resetn=0): count=0, out_valid=0, out_inst=0, out_pc=0, out_cls=0, out_rsv=0, out_in_ds=0, delay-slot flag=0, pointers=0.
- Handshake events: push = in_valid & in_ready. Fire = out_valid & out_ready. Load = (!out_valid | out_ready) & a source is available.
- Load source: FIFO head if count>0. Otherwise, bypass of the in_* beat when count==0 & push.
- Latency: empty queue with a free output stage gives out_valid in the cycle after the push (1 cycle). Buffered entries leave in FIFO order, one per cycle.
- A push not consumed by bypass is written at the write pointer. Pointers wrap modulo DEPTH.
- Simultaneous push and head load: count unchanged, and the new beat is written behind the old head.
- Full (count==DEPTH): in_ready=0. There is no same-cycle pass-through when full.
- out_valid=1 & out_ready=0: all out_* hold stable. No load occurs; the FIFO keeps filling until full.
- Classification per MIPS32 encoding, exact field checks:
  - r-type ALU ops require sa==0.
  - Immediate shifts require rs==0.
  - mult/div require rd==0 & sa==0.
  - lui requires rs==0.
  - REGIMM accepts rt in {0,1,16,17}.
  - mfc0/mtc0 require sa==0 & funct[4:3]==0.
  - eret must be exact.
- out_rsv = !(|class), registered with the class.
- Delay slot:
  - On each load, out_in_ds <= ds_flag.
  - ds_flag <= class[1] of the loaded instruction.
  - ds_flag is unchanged on cycles without a load.
  - A branch in a delay slot still sets ds_flag.
- Flush (synchronous, highest priority):
  - Next edge: count=0, pointers=0, out_valid=0, ds_flag=0.
  - A push in the flush cycle is discarded even though in_ready was 1.
  - A fire in the flush cycle still completes at EX.
  - Data fields may keep stale values.
- Reset mid-operation: all state returns to reset values immediately. Behaviour matches a cold start after the next edge with resetn=1.

Decomposition:
- Shared package mips_isa_pkg: opcode/funct/REGIMM-rt constants and CLS_* bit-index localparams, shared with the existing decoder and EX.
- Sub-module inst_classify: pure combinational, inst[31:0] -> cls[7:0], rsv.
- decode_queue owns the FIFO, bypass, output register, ds flag and flush.

Test Plan:
- Empty queue, out_ready=1; push addu 0x00851021 @pc 0xBFC00000 at cycle 0 -> cycle 1: out_valid=1, out_cls=8'h40, out_rsv=0, out_in_ds=0, count=0.
- out_ready=0; push 5 instructions with DEPTH=4 -> first in output register, count=4, in_ready=0. Set out_ready=1 -> drains in order one per cycle, and in_ready rises the cycle after the first head load.
- Push beq 0x10220003, then lw 0x8C430000, then sw -> beq cls=8'h02 ds=0; lw cls=8'h20 ds=1; sw cls=8'h10 ds=0.
- Push 0xFC000000 and sll with rs!=0 (0x00221080) -> both out_rsv=1, out_cls=0.
- Three buffered entries, jal in the output register, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; the following push gets out_in_ds=0.
- Two entries buffered; deassert resetn asynchronously mid-cycle -> outputs and count go to 0 before the next edge; pushes after release behave as from a cold start.
